mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter between the instruction cache and the data cache and the single shared RAM port. It sits directly downstream of both caches. Each cache drives a word-level request/wait handshake. The arbiter grants one cache at a time, holds the grant for a whole data-cache block transfer, and forwards the RAM response back to the owner.

## Interface
Parameters:
- STARVE_LIMIT, default 16: number of cycles the icache may wait while the dcache holds the port before a forced hand-over at the next dcache block boundary.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low only in the cycle the icache access completes.
- iload  out  32  icache read data; equals ramload at all times.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low only in the cycle the dcache access completes.
- dload  out  32  dcache read data; equals ramload at all times.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

## Operation
- Owner register with three states: IDLE, ISERV, DSERV. RAM outputs are driven combinationally from the owner.
- IDLE:
  - RAM strobes 0, ramaddr 0, ramstore 0.
  - If dREN|dWEN, go to DSERV (data has priority).
  - Else if iREN, go to ISERV.
  - Else stay in IDLE.
- ISERV:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - An access completes in the cycle ramstate==ACCESS.
  - After a completion, or if iREN drops: go to DSERV if dREN|dWEN, else ISERV if iREN, else IDLE.
- DSERV:
  - ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - A 1-bit word counter toggles on each completion and clears when DSERV is left.
  - The grant holds while dREN|dWEN stays high. When the request drops, go to ISERV if iREN, else IDLE.
- Starvation counter:
  - Increments each cycle in DSERV with iREN=1 and saturates at STARVE_LIMIT.
  - Clears on entry to ISERV.
  - When saturated, a completion that sets the word counter back to 0 (second word of a block) forces DSERV→ISERV even if the dcache still requests.
  - The dcache then waits (dwait=1) until ISERV completes one access.
- Wait signals: iwait = ~(owner==ISERV && ramstate==ACCESS). dwait = ~(owner==DSERV && ramstate==ACCESS). The non-owner's wait is always 1.
- ERROR and BUSY are non-completions. Wait stays high and the strobes stay asserted.
- A request dropped mid-access in ISERV or DSERV is abandoned. The owner leaves on the next edge, per the rules above.

## Timing
- Reset (async, immediate): owner=IDLE, counters 0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
- Arbitration costs one cycle:
  - Request seen in cycle n; owner updates at edge n+1; RAM strobe is asserted in cycle n+1.
  - Earliest completion (wait low) is cycle n+1, if ramstate==ACCESS then.
- Back-to-back dcache words: no bubble. The second word's strobe is driven in the cycle after the first completes.
- Hand-over after a completion takes effect at the next edge. The new owner's strobe is asserted in that cycle.
- Reset asserted mid-access drops the strobes in the same cycle. The access is lost and no completion is reported.

## Test plan
- Reset: hold nRST=0 with all requests high → ramREN=ramWEN=0, iwait=dwait=1. After release, the first grant goes to DSERV.
- Single icache read: iREN=1, iaddr=0x40, RAM ACCESS on the 2nd cycle with ramload=0xDEADBEEF → iwait low exactly that cycle, iload=0xDEADBEEF, then IDLE.
- Simultaneous iREN and dREN in IDLE: the dcache is served first. Two dcache words (0x100, 0x104) complete without a bubble. Then the icache is granted on the edge after dREN drops.
- dREN=dWEN=1 with daddr=0x200, dstore=0x12345678 → ramWEN=1, ramREN=0, ramaddr=0x200, ramstore=0x12345678.
- Starvation: STARVE_LIMIT=4, dcache requests continuously, iREN held high → after the saturating block's second word the port moves to ISERV. Exactly one icache access completes, then the grant returns to DSERV.
- ramstate=ERROR for 3 cycles then ACCESS → the owner's wait stays high for 3 cycles and the strobes stay asserted. Completion happens on the 4th cycle. Assert nRST low mid-access in a second run → the strobes drop immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Shares one RAM port between icache and dcache: dcache first, block-held  |
// | dcache grants, and a starvation hand-over to the icache.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int STARVE_LIMIT = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   localparam int         c_starve_w = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0] c_ACCESS   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISERV = 2'd1,
      DSERV = 2'd2
   } owner_t;

   owner_t                r_owner;
   owner_t                w_next;
   logic                  r_word;
   logic [c_starve_w-1:0] r_starve;
   logic                  w_dreq;
   logic                  w_acc;
   logic                  w_sat;

   assign w_dreq = dREN | dWEN;
   assign w_acc  = (ramstate == c_ACCESS);
   assign w_sat  = (r_starve == c_starve_w'(STARVE_LIMIT));
   assign iload  = ramload;
   assign dload  = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_owner  <= IDLE;
         r_word   <= 1'b0;
         r_starve <= '0;
      end else begin
         r_owner <= w_next;
         // Word counter tracks position inside a two-word dcache block
         r_word  <= (r_owner == DSERV && w_next == DSERV) ? (r_word ^ w_acc) : 1'b0;
         if (w_next == ISERV && r_owner != ISERV)
            r_starve <= '0;
         else if (r_owner == DSERV && iREN && !w_sat)
            r_starve <= r_starve + c_starve_w'(1);
      end
   end

   always_comb begin
      w_next   = r_owner;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (r_owner)
         IDLE: begin
            if (w_dreq)
               w_next = DSERV;
            else if (iREN)
               w_next = ISERV;
         end
         ISERV: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iwait   = ~w_acc;
            if (w_acc || !iREN)
               w_next = w_dreq ? DSERV : (iREN ? ISERV : IDLE);
         end
         DSERV: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = ~w_acc;
            // A starved icache takes over only once a block's second word completes
            if (!w_dreq)
               w_next = iREN ? ISERV : IDLE;
            else if (w_sat && w_acc && r_word)
               w_next = ISERV;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
`default_nettype wire
